// File: rtl/l1_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter and sequencer in front of the L1 cache CPU port.
// Optional per-port grant counters are built only when ARB_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a request; picks a winner and latches its address, WE and write data
// BUSY    | transaction presented to the cache; waits for CPU_ACK or the timeout
// RELEASE | owner ACK pulse is visible; CPU_Request held low for one cycle
module l1_port_arbiter #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_BUFFER_WIDTH = 32,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         I_Request,
  input  logic [ADDRESS_WIDTH-1:0]     I_Address,
  output logic [DATA_BUFFER_WIDTH-1:0] I_dataOut,
  output logic                         I_ACK,
  input  logic                         D_Request,
  input  logic                         D_WE,
  input  logic [ADDRESS_WIDTH-1:0]     D_Address,
  input  logic [DATA_BUFFER_WIDTH-1:0] D_dataIn,
  output logic [DATA_BUFFER_WIDTH-1:0] D_dataOut,
  output logic                         D_ACK,
  output logic                         CPU_Request,
  output logic [ADDRESS_WIDTH-1:0]     CPU_Address,
  output logic                         CPU_WE,
  output logic [DATA_BUFFER_WIDTH-1:0] Cache_dataOut,
  output logic                         Cache_dataOE,
  input  logic [DATA_BUFFER_WIDTH-1:0] Cache_dataIn,
  input  logic                         CPU_ACK,
  output logic                         Grant_Owner,
  output logic                         Timeout_Err,
  output logic [31:0]                  I_GrantCount,
  output logic [31:0]                  D_GrantCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       d_wins;
  logic       tmo_hit;
  logic       grant_done;

  // Grant_Owner doubles as the round-robin pointer; its reset value (I) hands D the first tie.
  always_comb begin
    d_wins     = D_Request && (!I_Request || !Grant_Owner);
    tmo_hit    = ({1'b0, tmo_cnt} + 9'd1) >= {1'b0, TMO_LIMIT};
    grant_done = (state == BUSY) && (CPU_ACK || tmo_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      I_dataOut     <= '0;
      I_ACK         <= 1'b0;
      D_dataOut     <= '0;
      D_ACK         <= 1'b0;
      CPU_Request   <= 1'b0;
      CPU_Address   <= '0;
      CPU_WE        <= 1'b0;
      Cache_dataOut <= '0;
      Cache_dataOE  <= 1'b0;
      Grant_Owner   <= 1'b0;
      Timeout_Err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_Request || D_Request) begin
            Grant_Owner   <= d_wins;
            CPU_Address   <= d_wins ? D_Address : I_Address;
            CPU_WE        <= d_wins && D_WE;
            Cache_dataOut <= d_wins ? D_dataIn : '0;
            Cache_dataOE  <= d_wins && D_WE;
            CPU_Request   <= 1'b1;
            tmo_cnt       <= '0;
            state         <= BUSY;
          end
        end

        BUSY: begin
          if (CPU_ACK) begin
            if (!CPU_WE) begin
              if (Grant_Owner) D_dataOut <= Cache_dataIn;
              else             I_dataOut <= Cache_dataIn;
            end
            if (Grant_Owner) D_ACK <= 1'b1;
            else             I_ACK <= 1'b1;
            CPU_Request  <= 1'b0;
            Cache_dataOE <= 1'b0;
            state        <= RELEASE;
          end else begin
            tmo_cnt <= (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
            // A stalled cache is released with zeroed data so the requester never hangs.
            if (tmo_hit) begin
              if (Grant_Owner) begin
                D_ACK     <= 1'b1;
                D_dataOut <= '0;
              end else begin
                I_ACK     <= 1'b1;
                I_dataOut <= '0;
              end
              Timeout_Err  <= 1'b1;
              CPU_Request  <= 1'b0;
              Cache_dataOE <= 1'b0;
              state        <= RELEASE;
            end
          end
        end

        RELEASE: begin
          I_ACK <= 1'b0;
          D_ACK <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      I_GrantCount <= '0;
      D_GrantCount <= '0;
    end else if (grant_done) begin
      if (Grant_Owner) D_GrantCount <= D_GrantCount + 32'd1;
      else             I_GrantCount <= I_GrantCount + 32'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done  = grant_done;
  assign I_GrantCount = '0;
  assign D_GrantCount = '0;
`endif

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Bench for l1_port_arbiter: timestamp-based transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_l1_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 4;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          I_Request, D_Request, D_WE, CPU_ACK;
  logic [AW-1:0] I_Address, D_Address;
  logic [DW-1:0] D_dataIn, Cache_dataIn;
  logic [DW-1:0] I_dataOut, D_dataOut, Cache_dataOut;
  logic          I_ACK, D_ACK, CPU_Request, CPU_WE, Cache_dataOE, Grant_Owner, Timeout_Err;
  logic [AW-1:0] CPU_Address;
  logic [31:0]   I_GrantCount, D_GrantCount;

  l1_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_BUFFER_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .I_Request(I_Request), .I_Address(I_Address), .I_dataOut(I_dataOut), .I_ACK(I_ACK),
    .D_Request(D_Request), .D_WE(D_WE), .D_Address(D_Address), .D_dataIn(D_dataIn),
    .D_dataOut(D_dataOut), .D_ACK(D_ACK),
    .CPU_Request(CPU_Request), .CPU_Address(CPU_Address), .CPU_WE(CPU_WE),
    .Cache_dataOut(Cache_dataOut), .Cache_dataOE(Cache_dataOE), .Cache_dataIn(Cache_dataIn),
    .CPU_ACK(CPU_ACK), .Grant_Owner(Grant_Owner), .Timeout_Err(Timeout_Err),
    .I_GrantCount(I_GrantCount), .D_GrantCount(D_GrantCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transaction model: each grant is a timestamp, completion is the first edge with CPU_ACK
  // or T edges after the grant, and requests are looked at again two edges after completion.
  int          cyc = 0;
  bit          m_valid = 1'b0;
  bit          m_busy, m_owner, m_we, m_err;
  int          m_gedge, m_free_at, m_ack_edge;
  logic [31:0] m_addr, m_wdata, m_idata, m_ddata, m_icnt, m_dcnt;
  int          mn, mk;
  bit          mown;

  always @(posedge clk) begin
    mn = cyc + 1;
    cyc <= mn;
    if (rst) begin
      m_valid <= 1'b1; m_busy <= 1'b0; m_owner <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_free_at <= mn + 1; m_ack_edge <= -10; m_gedge <= 0;
      m_addr <= '0; m_wdata <= '0; m_idata <= '0; m_ddata <= '0; m_icnt <= '0; m_dcnt <= '0;
    end else if (m_valid && m_busy) begin
      mk = mn - m_gedge;
      if (CPU_ACK || mk >= T) begin
        m_busy <= 1'b0;
        m_ack_edge <= mn;
        m_free_at <= mn + 2;
        if (m_owner) m_dcnt <= m_dcnt + 1; else m_icnt <= m_icnt + 1;
        if (!CPU_ACK) begin
          m_err <= 1'b1;
          if (m_owner) m_ddata <= '0; else m_idata <= '0;
        end else if (!m_we) begin
          if (m_owner) m_ddata <= Cache_dataIn; else m_idata <= Cache_dataIn;
        end
      end
    end else if (m_valid && mn >= m_free_at && (I_Request || D_Request)) begin
      mown = (I_Request && D_Request) ? !m_owner : D_Request;
      m_owner <= mown;
      m_busy  <= 1'b1;
      m_gedge <= mn;
      m_addr  <= mown ? D_Address : I_Address;
      m_we    <= mown && D_WE;
      m_wdata <= mown ? D_dataIn : '0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cpu_request", CPU_Request, m_busy);
      chk("i_ack", I_ACK, (m_ack_edge == cyc) && !m_owner);
      chk("d_ack", D_ACK, (m_ack_edge == cyc) && m_owner);
      chk("grant_owner", Grant_Owner, m_owner);
      chk("cache_oe", Cache_dataOE, m_busy && m_we);
      chk("i_data", I_dataOut, m_idata);
      chk("d_data", D_dataOut, m_ddata);
      chk("timeout_err", Timeout_Err, m_err);
      chk("i_count", I_GrantCount, STATS ? m_icnt : 32'd0);
      chk("d_count", D_GrantCount, STATS ? m_dcnt : 32'd0);
      if (m_busy) begin
        chk("cpu_addr", CPU_Address, m_addr);
        chk("cpu_we", CPU_WE, m_we);
        if (m_we) chk("cache_wdata", Cache_dataOut, m_wdata);
      end
    end
  end

  // Cache responder: acks after ack_delay busy cycles (0 = never), plus an optional stray pulse.
  int          ack_delay = 0;
  bit          idle_pulse = 1'b0;
  logic [31:0] rdata = '0;

  initial begin : cache_model
    int busy_n;
    busy_n = 0;
    CPU_ACK = 1'b0;
    Cache_dataIn = '0;
    forever begin
      @(negedge clk);
      if (CPU_Request) busy_n++;
      else busy_n = 0;
      CPU_ACK = ((ack_delay != 0) && (busy_n == ack_delay)) || idle_pulse;
      Cache_dataIn = rdata;
    end
  end

  int          g, a, nreq, ni, oe_n;
  bit          own, we_or;
  logic [31:0] wd, ad;

  // which: 0 = I_ACK, 1 = D_ACK, 2 = either
  task automatic wait_ack(input int which);
    bit done;
    done = 1'b0; g = -1; a = -1; own = 1'b0; nreq = 0; ni = 0; oe_n = 0;
    we_or = 1'b0; wd = '0; ad = '0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (CPU_Request) begin
        nreq++;
        if (g < 0) g = cyc;
        we_or = we_or | CPU_WE;
        ad = CPU_Address;
        if (Cache_dataOE) begin
          oe_n++;
          wd = Cache_dataOut;
        end
      end
      if (I_ACK) ni++;
      if ((which == 0 && I_ACK) || (which == 1 && D_ACK) || (which == 2 && (I_ACK || D_ACK))) begin
        done = 1'b1;
        a = cyc;
        own = D_ACK;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wait_ack: no ACK within 100 cycles (port %0d)", which);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [5:0] ord;
  int         g_first;

  initial begin : stimulus
    rst = 1'b1; I_Request = 1'b0; D_Request = 1'b0; D_WE = 1'b0;
    I_Address = '0; D_Address = '0; D_dataIn = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_req", CPU_Request, 0);
    chk("rst_acks", {I_ACK, D_ACK}, 0);
    chk("rst_owner_err", {Grant_Owner, Timeout_Err}, 0);
    chk("rst_data", {I_dataOut, D_dataOut}, 0);
    rst = 1'b0;

    // D read alone
    ack_delay = 1; rdata = 32'hDEAD_BEEF;
    D_WE = 1'b0; D_Address = 32'h0000_1230; D_Request = 1'b1;
    wait_ack(1);
    D_Request = 1'b0;
    chk("t1_req_cycles", nreq, 1);
    chk("t1_latency", a - g, 1);
    chk("t1_we", we_or, 0);
    chk("t1_addr", ad, 32'h0000_1230);
    chk("t1_d_data", D_dataOut, 32'hDEAD_BEEF);
    chk("t1_no_i_ack", ni, 0);
    chk("t1_model_ddata", m_ddata, 32'hDEAD_BEEF);

    // D write
    repeat (2) @(negedge clk);
    ack_delay = 2; rdata = 32'hFFFF_0000;
    D_WE = 1'b1; D_Address = 32'h0000_4560; D_dataIn = 32'h1234_5678; D_Request = 1'b1;
    wait_ack(1);
    D_Request = 1'b0; D_WE = 1'b0;
    chk("t2_busy_cycles", nreq, 2);
    chk("t2_oe_cycles", oe_n, 2);
    chk("t2_we", we_or, 1);
    chk("t2_wdata", wd, 32'h1234_5678);
    chk("t2_d_data_kept", D_dataOut, 32'hDEAD_BEEF);

    // Both ports requesting continuously from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 1; rdata = 32'h1111_0000;
    I_Address = 32'h0000_8000; D_Address = 32'h0000_9000;
    I_Request = 1'b1; D_Request = 1'b1;
    ord = '0; g_first = -1;
    for (int i = 0; i < 6; i++) begin
      wait_ack(2);
      if (g_first < 0) g_first = g;
      ord = {ord[4:0], own};
    end
    I_Request = 1'b0; D_Request = 1'b0;
    chk("t3_order", ord, 6'b101010);
    chk("t3_span", a - g_first, 16);
    chk("t3_i_count", I_GrantCount, STATS ? 32'd3 : 32'd0);
    chk("t3_d_count", D_GrantCount, STATS ? 32'd3 : 32'd0);

    // Cache never acks
    repeat (2) @(negedge clk);
    ack_delay = 0;
    D_Address = 32'h0000_ABC0; D_Request = 1'b1;
    wait_ack(1);
    D_Request = 1'b0;
    chk("t4_timeout_latency", a - g, T);
    chk("t4_d_data_zero", D_dataOut, 0);
    chk("t4_err_set", Timeout_Err, 1);
    chk("t4_model_err", m_err, 1);
    ack_delay = 1; rdata = 32'h0BAD_F00D;
    I_Address = 32'h0000_0100; I_Request = 1'b1;
    wait_ack(0);
    I_Request = 1'b0;
    chk("t4_i_data", I_dataOut, 32'h0BAD_F00D);
    chk("t4_err_sticky", Timeout_Err, 1);

    // Reset in the second BUSY cycle of an I fetch
    repeat (2) @(negedge clk);
    ack_delay = 0;
    I_Address = 32'h0000_2000; I_Request = 1'b1;
    for (int i = 0; i < 10 && !CPU_Request; i++) @(negedge clk);
    @(negedge clk);
    chk("t5_still_busy", CPU_Request, 1);
    rst = 1'b1; I_Request = 1'b0;
    @(negedge clk);
    chk("t5_req_cleared", CPU_Request, 0);
    chk("t5_no_i_ack", I_ACK, 0);
    chk("t5_err_cleared", Timeout_Err, 0);
    chk("t5_outputs_zero", {CPU_Address, CPU_WE, Cache_dataOE, Grant_Owner, I_dataOut}, 0);
    rst = 1'b0;
    ack_delay = 1; rdata = 32'h5555_AAAA;
    D_Address = 32'h0000_7000; D_WE = 1'b0;
    I_Request = 1'b1; D_Request = 1'b1;
    wait_ack(2);
    D_Request = 1'b0;
    chk("t5_d_first", own, 1);
    wait_ack(0);
    I_Request = 1'b0;
    chk("t5_i_second", I_dataOut, 32'h5555_AAAA);

    // Stray CPU_ACK in IDLE, then CPU_ACK on the edge the count reaches the limit
    repeat (3) @(negedge clk);
    @(posedge clk);
    idle_pulse = 1'b1;
    @(posedge clk);
    idle_pulse = 1'b0;
    @(negedge clk);
    chk("t6_idle_no_req", CPU_Request, 0);
    chk("t6_idle_no_ack", {I_ACK, D_ACK}, 0);
    ack_delay = T; rdata = 32'hCAFE_0004;
    D_Address = 32'h0000_3330; D_Request = 1'b1;
    wait_ack(1);
    D_Request = 1'b0;
    chk("t6_ack_latency", a - g, T);
    chk("t6_d_data", D_dataOut, 32'hCAFE_0004);
    chk("t6_no_err", Timeout_Err, 0);
    chk("t6_model_err", m_err, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
